// File: rtl/shift_ram_window.sv
// Multi-row shift-register line buffer with sliding window read; SHIFT_RAM_BYPASS_EN forwards same-row writes to reads.
// Read latency 1 cycle; wr_ready drops while a bulk clear is requested or running, reads never stall.
module shift_ram_window #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 25,
  parameter int WIN        = 5,
  parameter int ADDR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [7:0]                   rd_offset,
  output logic [DATA_WIDTH*LENGTH-1:0] dout,
  output logic [DATA_WIDTH*WIN-1:0]    win_out,
  output logic                         dout_valid,
  output logic                         row_full,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(LENGTH + 1);
  localparam logic [ADDR_W:0]    DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(LENGTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state;
  logic [IDX_W-1:0]      clr_idx;
  logic [DATA_WIDTH-1:0] mem  [DEPTH][LENGTH];
  logic [FILL_W-1:0]     fill [DEPTH];

  logic                  wr_hit, rd_hit, wr_fire, rd_full;
  logic [IDX_W-1:0]      wr_row, rd_row;
  logic [DATA_WIDTH-1:0] rd_words [LENGTH];
  logic [DATA_WIDTH*LENGTH-1:0] dout_d;
  logic [DATA_WIDTH*WIN-1:0]    win_d;

  assign wr_hit   = {1'b0, wr_addr} < DEPTH_A;
  assign rd_hit   = {1'b0, rd_addr} < DEPTH_A;
  assign wr_row   = wr_addr[IDX_W-1:0];
  assign rd_row   = rd_addr[IDX_W-1:0];
  assign wr_ready = (state == IDLE) && !clr_req;
  assign wr_fire  = wr_valid && wr_ready && wr_hit;
  assign busy     = (state == CLEAR);

  // Out-of-range rows read as an empty row.
  always_comb begin
    for (int k = 0; k < LENGTH; k++) rd_words[k] = '0;
    rd_full = 1'b0;
    if (rd_hit) begin
      for (int k = 0; k < LENGTH; k++) rd_words[k] = mem[rd_row][k];
      rd_full = (fill[rd_row] == FILL_MAX);
`ifdef SHIFT_RAM_BYPASS_EN
      if (wr_fire && (wr_row == rd_row)) begin
        for (int k = 0; k < LENGTH - 1; k++) rd_words[k] = mem[rd_row][k+1];
        rd_words[LENGTH-1] = din;
        rd_full = (fill[rd_row] >= FILL_MAX - 1'b1);
      end
`endif
    end
  end

  // Window words past the end of the row read as zero.
  always_comb begin
    dout_d = '0;
    win_d  = '0;
    for (int k = 0; k < LENGTH; k++) dout_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_words[k];
    for (int j = 0; j < WIN; j++) begin
      for (int k = 0; k < LENGTH; k++) begin
        if (k == int'(rd_offset) + j) win_d[j*DATA_WIDTH +: DATA_WIDTH] = rd_words[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_idx    <= '0;
      dout       <= '0;
      win_out    <= '0;
      dout_valid <= 1'b0;
      row_full   <= 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        fill[r] <= '0;
        for (int k = 0; k < LENGTH; k++) mem[r][k] <= '0;
      end
    end else begin
      dout_valid <= rd_en;
      if (rd_en) begin
        dout     <= dout_d;
        win_out  <= win_d;
        row_full <= rd_full;
      end

      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          fill[clr_idx] <= '0;
          for (int k = 0; k < LENGTH; k++) mem[clr_idx][k] <= '0;
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Writes are only accepted in IDLE, so they never collide with a clear.
      if (wr_fire) begin
        for (int k = 0; k < LENGTH - 1; k++) mem[wr_row][k] <= mem[wr_row][k+1];
        mem[wr_row][LENGTH-1] <= din;
        if (fill[wr_row] != FILL_MAX) fill[wr_row] <= fill[wr_row] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_ram_window.sv
// Scoreboard bench for shift_ram_window: each row is modelled as the history of its last LENGTH writes.
module tb_shift_ram_window;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int LEN   = 25;
  localparam int WIN   = 5;
  localparam int AW    = 8;
  localparam int CW    = DW * LEN;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  din = '0;
  logic           rd_en = 1'b0;
  logic [AW-1:0]  rd_addr = '0;
  logic [7:0]     rd_offset = '0;
  logic [CW-1:0]  dout;
  logic [DW*WIN-1:0] win_out;
  logic           dout_valid;
  logic           row_full;
  logic           clr_req = 1'b0;
  logic           busy;

  always #5 clk = ~clk;

  shift_ram_window #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .LENGTH(LEN), .WIN(WIN), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_offset(rd_offset),
    .dout(dout), .win_out(win_out), .dout_valid(dout_valid), .row_full(row_full),
    .clr_req(clr_req), .busy(busy)
  );

  typedef struct {
    logic [CW-1:0]     d;
    logic [DW*WIN-1:0] w;
    logic              f;
    int                cyc;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DW-1:0]     hist [DEPTH][$];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  logic              m_busy = 1'b0;
  int                m_idx = 0;
  logic [CW-1:0]     last_d = '0;
  logic [DW*WIN-1:0] last_w = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; expectations come from the history model before the edge.
  task automatic cyc_do(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic re, input logic [AW-1:0] ra, input logic [7:0] ro,
                        input logic cr);
    logic          acc;
    exp_t          e;
    logic [DW-1:0] h[$];
    int            n;
    wr_valid = wv; wr_addr = wa; din = d;
    rd_en = re; rd_addr = ra; rd_offset = ro; clr_req = cr;
    #1;
    acc = wv && !m_busy && !cr;
    chk("wr_ready", CW'(wr_ready), CW'(!m_busy && !cr));
    chk("busy", CW'(busy), CW'(m_busy));
    if (re) begin
      e.d = '0; e.w = '0; e.f = 1'b0; e.cyc = cyc + 1;
      if (int'(ra) < DEPTH) begin
        h = hist[int'(ra)];
`ifdef SHIFT_RAM_BYPASS_EN
        if (acc && wa == ra) begin
          h.push_back(d);
          if (h.size() > LEN) void'(h.pop_front());
        end
`endif
        n = h.size();
        for (int k = LEN - n; k < LEN; k++) e.d[k*DW +: DW] = h[k-(LEN-n)];
        e.f = (n == LEN);
        for (int j = 0; j < WIN; j++)
          if (int'(ro) + j < LEN) e.w[j*DW +: DW] = e.d[(int'(ro)+j)*DW +: DW];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    if (m_busy) begin
      hist[m_idx].delete();
      m_idx++;
      if (m_idx == DEPTH) m_busy = 1'b0;
    end else if (cr) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (acc && int'(wa) < DEPTH) begin
      hist[int'(wa)].push_back(d);
      if (hist[int'(wa)].size() > LEN) void'(hist[int'(wa)].pop_front());
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_do(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr(input int row, input logic [DW-1:0] d);
    cyc_do(1'b1, AW'(row), d, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input int row, input int off);
    cyc_do(1'b0, '0, '0, 1'b1, AW'(row), 8'(off), 1'b0);
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) hist[r].delete();
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  // Monitor: every cycle either a scheduled read result or an idle, held output.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_d <= '0;
      last_w <= '0;
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk("dout_valid", CW'(dout_valid), CW'(1'b1));
      chk("dout", dout, mon_e.d);
      chk("win_out", CW'(win_out), CW'(mon_e.w));
      chk("row_full", CW'(row_full), CW'(mon_e.f));
      last_d <= mon_e.d;
      last_w <= mon_e.w;
    end else begin
      chk("dout_valid_idle", CW'(dout_valid), CW'(1'b0));
      chk("dout_hold", dout, last_d);
      chk("win_hold", CW'(win_out), CW'(last_w));
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_dout", dout, '0);
    chk("rst_win", CW'(win_out), '0);
    chk("rst_valid", CW'(dout_valid), '0);
    chk("rst_full", CW'(row_full), '0);
    chk("rst_busy", CW'(busy), '0);
    chk("rst_wr_ready", CW'(wr_ready), CW'(1'b1));
    @(posedge clk); #1;

    // Row 3 loaded with 1..25, full-row and tail-window reads.
    for (int i = 1; i <= LEN; i++) wr(3, DW'(i));
    rd(3, 0);
    rd(3, 22);
    rd(3, 20);

    // Fill saturation boundary on row 5.
    for (int i = 1; i <= 24; i++) wr(5, DW'(16'h0500 + i));
    rd(5, 0);
    wr(5, 16'h0519);
    rd(5, 0);
    for (int i = 26; i <= 30; i++) wr(5, DW'(16'h0500 + i));
    rd(5, 3);

    // Same-cycle write and read of row 2.
    for (int i = 0; i < 10; i++) wr(2, DW'(16'h0200 + i));
    cyc_do(1'b1, 8'd2, 16'hBEEF, 1'b1, 8'd2, 8'd21, 1'b0);
    rd(2, 21);

    // Fill every row, then clear while hammering writes and reads.
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < LEN + 1; i++) wr(r, DW'($urandom));
    cyc_do(1'b1, 8'd7, 16'h7777, 1'b1, 8'd7, 8'd0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc_do(1'b1, AW'($urandom_range(0, DEPTH-1)), DW'($urandom), 1'b1,
             AW'($urandom_range(0, DEPTH-1)), 8'($urandom_range(0, 30)), 1'(i == 3));
    for (int r = 0; r < DEPTH; r++) rd(r, r);

    // Reset in the middle of a clear, then out-of-range accesses.
    for (int r = 0; r < DEPTH; r++) wr(r, DW'($urandom));
    cyc_do(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(5);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_rst_busy", CW'(busy), '0);
    chk("mid_rst_wr_ready", CW'(wr_ready), CW'(1'b1));
    chk("mid_rst_dout", dout, '0);
    @(posedge clk); #1;
    for (int r = 0; r < DEPTH; r++) rd(r, 0);
    wr(20, 16'hDEAD);
    rd(20, 0);
    for (int r = 0; r < DEPTH; r++) rd(r, 0);

    // Randomized traffic with occasional clears and out-of-range addresses.
    for (int i = 0; i < 3000; i++)
      cyc_do(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, DEPTH+1)), DW'($urandom),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH+1)),
             8'($urandom_range(0, 30)), 1'($urandom_range(0, 799) == 0));

    idle(3);
    chk("sb_drained", CW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_ram_window.md
Name: shift_ram_window

Overview:
- Multi-row shift-register line buffer for the n4 convolution datapath.
- Each of DEPTH rows holds LENGTH words; writing a word to a row shifts it in at the top end.
- Read port returns the full row plus a WIN-word sliding window at a programmable offset, a per-row fill status and an output-valid strobe.
- Adds a write handshake and a sequenced bulk clear, so rows can be recycled between feature-map tiles without a global reset.

Parameters:
- DEPTH, 16, number of rows.
- DATA_WIDTH, 16, bits per word.
- LENGTH, 25, words per row.
- WIN, 5, words in the window output; must satisfy 1 <= WIN <= LENGTH.
- ADDR_W, 8, width of row address ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  target row of write.
- din  in  DATA_WIDTH  word to shift in.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  row to read.
- rd_offset  in  8  index of first window word.
- dout  out  DATA_WIDTH*LENGTH  full row; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- win_out  out  DATA_WIDTH*WIN  window; word j = row word rd_offset+j.
- dout_valid  out  1  dout/win_out/row_full valid.
- row_full  out  1  read row has received >= LENGTH words since last clear.
- clr_req  in  1  pulse: start bulk clear of all rows.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset, asynchronous: all row words 0, all fill counters 0, FSM in IDLE; outputs dout=0, win_out=0, dout_valid=0, row_full=0, busy=0, wr_ready=1.
- Word order: word LENGTH-1 is newest, word 0 is oldest.
- Write: accepted write to row r sets row[r] = {din, row[r][LENGTH-1:1]}; the oldest word is discarded.
- fill[r] increments on each accepted write and saturates at LENGTH.
- Writes with wr_addr >= DEPTH: handshake completes, no state change.
- wr_ready = (state == IDLE) && !clr_req.
- Read latency is 1 cycle. On rd_en at edge N, at edge N+1 the block presents:
  - dout_valid=1;
  - dout = row contents before any same-cycle write (read-old semantics);
  - row_full = (fill == LENGTH), also sampled pre-write;
  - win_out as defined below.
- dout_valid=0 in any cycle after which rd_en was low; dout/win_out hold their last value.
- Window: word j = row word rd_offset+j if rd_offset+j < LENGTH, else 0.
- Reads with rd_addr >= DEPTH return dout=0, win_out=0, row_full=0 with dout_valid=1.
- Reads are allowed during CLEAR and return the current (partially cleared) contents.
- FSM states:
  - IDLE: clr_req -> CLEAR; clear index <= 0; busy=1 from the next cycle.
  - CLEAR: each cycle, row[idx] <= 0 and fill[idx] <= 0, then idx++. After clearing row DEPTH-1, go to IDLE. Total DEPTH cycles with busy=1.
  - clr_req while in CLEAR is ignored.
- Same-cycle wr_valid and clr_req in IDLE: wr_ready is low, so the write is not accepted; the clear starts.
- Fill counter width is clog2(LENGTH+1); no wrap.

Optional Feature:
- Macro: SHIFT_RAM_BYPASS_EN.
- Defined: a read of the same row as a same-cycle accepted write returns the post-write row; row_full reflects the post-write fill.
- Undefined: read-old semantics as above.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then write 0x0001..0x0019 to row 3, then read row 3 -> dout word 0 = 0x0001, word 24 = 0x0019, row_full=1, dout_valid=1 exactly one cycle after rd_en.
- Write 24 words to row 5, then read -> row_full=0. One more write, then read -> row_full=1. 30 total writes -> word 0 = 6th word written.
- Row 3 loaded as in the first test, read with rd_offset=22 and WIN=5 -> win_out words = 0x0017, 0x0018, 0x0019, 0, 0.
- Write to row 2 and read row 2 in the same cycle -> without the macro, dout lacks the new word; with SHIFT_RAM_BYPASS_EN, word 24 = new din.
- Fill rows 0..15, pulse clr_req -> busy high for 16 cycles, wr_ready low throughout, writes during busy are not applied. Afterwards every row reads 0 with row_full=0.
- Assert rst_n low mid-CLEAR for one cycle -> busy=0, wr_ready=1, all rows 0. Write to wr_addr=20 -> no effect; read rd_addr=20 -> dout=0, dout_valid=1.
